// File: rtl/alu_control_issue.sv
// LEGv8 ALU-control issue stage: decodes opcode/ALUOp at push time into a 2-entry FIFO
// of {illegal, code} entries, with valid/ready on both sides and a saturating illegal counter.
module alu_control_issue (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [10:0] Opcode,
    input  logic [1:0]  ALUOp,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [3:0]  ALUCntrlOperation,
    output logic        Illegal,
    output logic [7:0]  IllegalCount
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [7:0] illegal_count_q, illegal_count_d;
    logic [4:0] mem_q [2];

    logic       push, pop;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic [4:0] head;

    // Decode defaults to the illegal tag; only exact table hits clear it.
    always_comb begin
        dec_code    = 4'b1111;
        dec_illegal = 1'b1;
        case (ALUOp)
            2'b00: begin
                dec_code    = 4'b0010;
                dec_illegal = 1'b0;
            end
            2'b01: begin
                if (Opcode[10:3] == 8'b10110100) begin
                    dec_code    = 4'b0111;
                    dec_illegal = 1'b0;
                end else if (Opcode[10:3] == 8'b10110101) begin
                    dec_code    = 4'b1000;
                    dec_illegal = 1'b0;
                end
            end
            2'b10: begin
                case (Opcode)
                    11'b10001011000: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                    11'b11001011000: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
                    11'b10001010000: begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                    11'b10101010000: begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
            default: begin
                case (Opcode[10:1])
                    10'b1001000100: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                    10'b1101000100: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    assign InReady  = (count_q != 2'd2);
    assign OutValid = (count_q != 2'd0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    always_comb begin
        count_d         = count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        illegal_count_d = illegal_count_q;
        // The counter sees every accepted illegal push, even one discarded by a flush.
        if (push && dec_illegal && (illegal_count_q != 8'hFF)) begin
            illegal_count_d = illegal_count_q + 8'd1;
        end
        if (Flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            illegal_count_q <= 8'd0;
            mem_q[0]        <= 5'd0;
            mem_q[1]        <= 5'd0;
        end else begin
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            illegal_count_q <= illegal_count_d;
            if (push && !Flush) begin
                mem_q[wr_ptr_q] <= {dec_illegal, dec_code};
            end
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign ALUCntrlOperation = OutValid ? head[3:0] : 4'b0000;
    assign Illegal           = OutValid ? head[4] : 1'b0;
    assign IllegalCount      = illegal_count_q;

endmodule

// File: tb/tb_alu_control_issue.sv
// Self-checking bench for alu_control_issue: queue-based reference model with a per-cycle
// compare process, directed literal checks and a randomized phase.
module tb_alu_control_issue;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [10:0] Opcode = 11'd0;
    logic [1:0]  ALUOp = 2'd0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [3:0]  ALUCntrlOperation;
    logic        Illegal;
    logic [7:0]  IllegalCount;

    alu_control_issue dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .Flush             (Flush),
        .InValid           (InValid),
        .InReady           (InReady),
        .Opcode            (Opcode),
        .ALUOp             (ALUOp),
        .OutValid          (OutValid),
        .OutReady          (OutReady),
        .ALUCntrlOperation (ALUCntrlOperation),
        .Illegal           (Illegal),
        .IllegalCount      (IllegalCount)
    );

    always #5 CLOCK = ~CLOCK;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    // Decode table: class, opcode value, care mask, code.
    logic [1:0]  ta [9] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [10:0] tv [9] = '{11'd0, 11'b10110100000, 11'b10110101000, OP_ADD, OP_SUB, OP_AND,
                            OP_ORR, 11'b10010001000, 11'b11010001000};
    logic [10:0] tm [9] = '{11'h000, 11'h7F8, 11'h7F8, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF,
                            11'h7FE, 11'h7FE};
    logic [3:0]  tc [9] = '{4'd2, 4'd7, 4'd8, 4'd2, 4'd6, 4'd0, 4'd1, 4'd2, 4'd6};

    int compared = 0;
    int mismatched = 0;
    logic [4:0] mq [$];
    int micnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [1:0] aop, input logic [10:0] opc);
        for (int k = 0; k < 9; k++) begin
            if (aop == ta[k] && (opc & tm[k]) == tv[k]) return {1'b0, tc[k]};
        end
        return 5'b11111;
    endfunction

    task automatic model_step(input bit iv, input logic [1:0] aop, input logic [10:0] opc,
                              input bit ordy, input bit fl);
        bit push, pop;
        logic [4:0] d;
        if (!RESET) begin
            mq.delete();
            micnt = 0;
            return;
        end
        push = iv && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        d    = ref_decode(aop, opc);
        if (push && d[4] && micnt < 255) micnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
        end
    endtask

    task automatic cycle(input bit iv, input logic [1:0] aop, input logic [10:0] opc,
                         input bit ordy, input bit fl);
        InValid  = iv;
        ALUOp    = aop;
        Opcode   = opc;
        OutReady = ordy;
        Flush    = fl;
        @(posedge CLOCK);
        model_step(iv, aop, opc, ordy, fl);
        @(negedge CLOCK);
        #1;
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check("out_valid", OutValid, mq.size() != 0);
            check("in_ready", InReady, mq.size() != 2);
            if (mq.size() != 0) begin
                check("code", ALUCntrlOperation, mq[0][3:0]);
                check("illegal", Illegal, mq[0][4]);
            end else begin
                check("code_empty", ALUCntrlOperation, 4'b0000);
                check("illegal_empty", Illegal, 1'b0);
            end
            check("illegal_count", IllegalCount, micnt);
        end
    end

    initial begin
        logic [4:0] lit [9];
        lit = '{5'h02, 5'h07, 5'h08, 5'h02, 5'h06, 5'h00, 5'h01, 5'h02, 5'h06};

        repeat (3) @(negedge CLOCK);
        #1;
        check("reset_out_valid", OutValid, 1'b0);
        check("reset_in_ready", InReady, 1'b1);
        check("reset_code", ALUCntrlOperation, 4'b0000);
        check("reset_icnt", IllegalCount, 8'd0);
        RESET  = 1'b1;
        chk_en = 1'b1;

        // Decode sweep, don't-care bits set to 1 to exercise masking.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, ta[k], tv[k] | ~tm[k], 1'b1, 1'b0);
            check("sweep_code", ALUCntrlOperation, lit[k][3:0]);
            check("sweep_illegal", Illegal, 1'b0);
            check("sweep_valid", OutValid, 1'b1);
        end
        cycle(1'b0, 2'b00, 11'd0, 1'b1, 1'b0);

        // Backpressure: third push held off until a slot frees.
        cycle(1'b1, 2'b10, OP_AND, 1'b0, 1'b0);
        check("full_ready1", InReady, 1'b1);
        cycle(1'b1, 2'b10, OP_ORR, 1'b0, 1'b0);
        check("full_ready2", InReady, 1'b0);
        check("full_head", ALUCntrlOperation, 4'b0000);
        cycle(1'b1, 2'b10, OP_SUB, 1'b0, 1'b0);
        check("full_hold_ready", InReady, 1'b0);
        check("full_hold_head", ALUCntrlOperation, 4'b0000);
        cycle(1'b1, 2'b10, OP_SUB, 1'b1, 1'b0);
        check("drain_orr", ALUCntrlOperation, 4'b0001);
        cycle(1'b1, 2'b10, OP_SUB, 1'b1, 1'b0);
        check("drain_sub", ALUCntrlOperation, 4'b0110);
        cycle(1'b0, 2'b10, OP_SUB, 1'b1, 1'b0);
        check("drain_empty", OutValid, 1'b0);

        // Simultaneous push/pop at one entry.
        cycle(1'b1, 2'b10, OP_ADD, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'b10, (i % 2 == 0) ? OP_SUB : OP_ADD, 1'b1, 1'b0);
            check("pp_code", ALUCntrlOperation, (i % 2 == 0) ? 4'b0110 : 4'b0010);
            check("pp_ready", InReady, 1'b1);
        end
        cycle(1'b0, 2'b00, 11'd0, 1'b1, 1'b0);

        // Illegal tagging and flush.
        cycle(1'b1, 2'b10, 11'h7FF, 1'b0, 1'b0);
        check("ill_code", ALUCntrlOperation, 4'b1111);
        check("ill_flag", Illegal, 1'b1);
        check("ill_count1", IllegalCount, 8'd1);
        cycle(1'b1, 2'b10, 11'h7FF, 1'b0, 1'b1);
        check("flush1_valid", OutValid, 1'b0);
        check("flush1_icnt", IllegalCount, 8'd2);
        cycle(1'b1, 2'b10, OP_ADD, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, OP_SUB, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, OP_AND, 1'b0, 1'b1);
        check("flush2_valid", OutValid, 1'b0);
        check("flush2_ready", InReady, 1'b1);
        cycle(1'b0, 2'b10, OP_AND, 1'b1, 1'b0);
        check("flush2_gone", OutValid, 1'b0);

        repeat (300) cycle(1'b1, 2'b11, 11'h7FF, 1'b1, 1'b0);
        check("ill_saturate", IllegalCount, 8'd255);
        cycle(1'b0, 2'b00, 11'd0, 1'b1, 1'b0);

        // Asynchronous reset with the FIFO full.
        cycle(1'b1, 2'b10, OP_ADD, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, OP_SUB, 1'b0, 1'b0);
        check("prereset_full", InReady, 1'b0);
        #2;
        RESET = 1'b0;
        mq.delete();
        micnt = 0;
        #1;
        check("areset_valid", OutValid, 1'b0);
        check("areset_ready", InReady, 1'b1);
        check("areset_code", ALUCntrlOperation, 4'b0000);
        check("areset_icnt", IllegalCount, 8'd0);
        cycle(1'b1, 2'b10, OP_ADD, 1'b1, 1'b0);
        cycle(1'b1, 2'b10, OP_ADD, 1'b1, 1'b0);
        RESET = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            int unsigned k;
            logic [10:0] opc;
            logic [1:0] aop;
            k = $urandom % 12;
            if (k < 9) begin
                aop = ta[k];
                opc = (tv[k] & tm[k]) | (11'($urandom) & ~tm[k]);
            end else begin
                aop = 2'($urandom);
                opc = 11'($urandom);
            end
            cycle(($urandom % 4) != 0, aop, opc, ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
